ps2_keyboard: RTL and testbench

PS2_KEYBOARD -- requirements
Module: ps2_keyboard

---
 rtl/ps2_keyboard.sv | 227 ++++++++++++++++++++++
 tb/tb_ps2_keyboard.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver: synchronises and de-glitches the PS/2 clock,
// assembles 11-bit frames (start, 8 data LSB-first, odd parity, stop),
// and queues good scancodes in a first-word fall-through FIFO for the CPU.
module ps2_keyboard #(
  parameter int unsigned FILTER  = 8,
  parameter int unsigned TIMEOUT = 50000,
  parameter int unsigned DEPTH   = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  input  logic       rd,
  input  logic       clr,
  output logic [7:0] o_data,
  output logic       ready,
  output logic       overflow,
  output logic       frame_err
);

  localparam int unsigned FW = $clog2(FILTER + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  // Line synchronisers and clock filter
  logic          clk_s1, clk_s2;
  logic          dat_s1, dat_s2;
  logic          clk_filt;
  logic [FW-1:0] filt_cnt;
  logic          fall_edge;

  // Receiver
  state_t        state, state_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shift, shift_n;
  logic          parity_ok, parity_ok_n;
  logic [TW-1:0] idle_cnt, idle_cnt_n;
  logic          push_q, push_n;
  logic          err_q, err_n;

  // FIFO
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [7:0]    last_q;
  logic          full;
  logic          do_push, do_pop, ovf_set;

  // Two-flop synchronisers; reset to the idle-high bus level
  always_ff @(posedge clock) begin
    if (reset) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_dat;
      dat_s2 <= dat_s1;
    end
  end

  // Filtered clock follows the synchronised level only after FILTER equal samples
  always_ff @(posedge clock) begin
    if (reset) begin
      clk_filt <= 1'b1;
      filt_cnt <= '0;
    end else if (clk_s2 == clk_filt) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FW'(FILTER - 1)) begin
      clk_filt <= clk_s2;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + FW'(1);
    end
  end

  // Falling edge is flagged in the same cycle the filtered level drops
  always_comb begin
    fall_edge = (clk_s2 != clk_filt) && (filt_cnt == FW'(FILTER - 1)) && !clk_s2;
  end

  // Receiver state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      parity_ok <= 1'b0;
      idle_cnt  <= '0;
      push_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      shift     <= shift_n;
      parity_ok <= parity_ok_n;
      idle_cnt  <= idle_cnt_n;
      push_q    <= push_n;
      err_q     <= err_n;
    end
  end

  // Frame decoding and inactivity timeout
  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    shift_n     = shift;
    parity_ok_n = parity_ok;
    idle_cnt_n  = idle_cnt;
    push_n      = 1'b0;
    err_n       = 1'b0;

    case (state)
      IDLE: begin
        idle_cnt_n = '0;
        if (fall_edge && !dat_s2) begin
          state_n   = DATA;
          bit_cnt_n = '0;
        end
      end
      DATA: begin
        if (fall_edge) begin
          shift_n   = {dat_s2, shift[7:1]};
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            state_n = PARITY;
          end
        end
      end
      PARITY: begin
        if (fall_edge) begin
          parity_ok_n = ^{shift, dat_s2};
          state_n     = STOP;
        end
      end
      STOP: begin
        if (fall_edge) begin
          if (dat_s2 && parity_ok) begin
            push_n = 1'b1;
          end else begin
            err_n = 1'b1;
          end
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // An edge restarts the idle count; a stalled partial frame is abandoned
    if (state != IDLE) begin
      if (fall_edge) begin
        idle_cnt_n = '0;
      end else if (idle_cnt == TW'(TIMEOUT - 1)) begin
        state_n    = IDLE;
        err_n      = 1'b1;
        idle_cnt_n = '0;
      end else begin
        idle_cnt_n = idle_cnt + TW'(1);
      end
    end
  end

  assign frame_err = err_q;

  // FIFO handshake: a simultaneous pop frees the slot a push into a full FIFO needs
  always_comb begin
    full    = (count == CW'(DEPTH));
    do_pop  = rd && ready;
    do_push = push_q && (!full || do_pop);
    ovf_set = push_q && full && !do_pop;
  end

  // Scancode storage; the shift register still holds the byte during the push cycle
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= shift;
    end
  end

  // FIFO pointers, occupancy, sticky overflow and last popped byte
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      last_q   <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        last_q <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (ovf_set) begin
        overflow <= 1'b1;
      end else if (clr) begin
        overflow <= 1'b0;
      end
    end
  end

  // Head of queue when non-empty, otherwise the byte most recently read
  always_comb begin
    ready  = (count != '0);
    o_data = ready ? mem[rd_ptr] : last_q;
  end

endmodule

// File: tb/tb_ps2_keyboard.sv
// Bench for ps2_keyboard: PS/2 frames are synthesised bit by bit; a queue
// holds the bytes the receiver should deliver, in order, and is drained
// either by directed reads or by a free-running read monitor.
module tb_ps2_keyboard;

  localparam int unsigned FILT = 4;
  localparam int unsigned TMO  = 2000;
  localparam int unsigned DEP  = 8;
  localparam int unsigned HALF = 40;

  logic       clock   = 1'b0;
  logic       reset   = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic       dir_rd  = 1'b0;
  logic       mon_rd  = 1'b0;
  logic       clr     = 1'b0;
  logic       rd;
  logic [7:0] o_data;
  logic       ready;
  logic       overflow;
  logic       frame_err;

  assign rd = dir_rd | mon_rd;

  ps2_keyboard #(
    .FILTER (FILT),
    .TIMEOUT(TMO),
    .DEPTH  (DEP)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_dat  (ps2_dat),
    .rd       (rd),
    .clr      (clr),
    .o_data   (o_data),
    .ready    (ready),
    .overflow (overflow),
    .frame_err(frame_err)
  );

  always #5 clock = ~clock;

  int         checks    = 0;
  int         errors    = 0;
  int         err_seen  = 0;
  int         exp_err   = 0;
  bit         exp_ovf   = 1'b0;
  bit         auto_read = 1'b0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One PS/2 bit: data settles mid-high, then a full low and high phase
  task automatic drive_bit(input logic b);
    ps2_dat = b;
    repeat (HALF / 2) @(negedge clock);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clock);
    ps2_clk = 1'b1;
    repeat (HALF / 2) @(negedge clock);
  endtask

  task automatic send_raw(input logic [7:0] d, input logic par, input logic stop, input int nbits);
    logic [10:0] bits;
    bits = {stop, par, d, 1'b0};
    for (int i = 0; i < nbits; i++) drive_bit(bits[i]);
    ps2_dat = 1'b1;
  endtask

  // Reference: a byte is delivered only with start 0, odd parity and stop 1,
  // and only while fewer than DEP bytes are waiting
  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
    logic par;
    par = (~^d) ^ bad_par;
    if (bad_par || bad_stop) exp_err++;
    else if (exp_q.size() < DEP) exp_q.push_back(d);
    else exp_ovf = 1'b1;
    send_raw(d, par, ~bad_stop, 11);
  endtask

  task automatic pop_check(input string name);
    check({name, "_ready"}, int'(ready), 1);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_data: got 0x%0h expected no byte", name, o_data);
    end else begin
      check({name, "_data"}, int'(o_data), int'(exp_q.pop_front()));
    end
    dir_rd = 1'b1;
    @(negedge clock);
    dir_rd = 1'b0;
  endtask

  // Stop bit whose push coincides with a read: the byte becomes valid two
  // synchroniser stages plus FILT filter samples after the line falls
  task automatic send_with_rd_at_push(input logic [7:0] d);
    send_raw(d, ~^d, 1'b1, 10);
    ps2_dat = 1'b1;
    repeat (HALF / 2) @(negedge clock);
    ps2_clk = 1'b0;
    repeat (2 + FILT) @(negedge clock);
    check("full_head_before", int'(o_data), int'(exp_q[0]));
    dir_rd = 1'b1;
    void'(exp_q.pop_front());
    exp_q.push_back(d);
    @(negedge clock);
    dir_rd = 1'b0;
    repeat (HALF - 3 - FILT) @(negedge clock);
    ps2_clk = 1'b1;
    repeat (HALF / 2) @(negedge clock);
  endtask

  // Count every cycle frame_err is high
  initial begin
    forever begin
      @(negedge clock);
      if (frame_err) err_seen++;
    end
  end

  // Scoreboard monitor: while enabled, pops each presented byte and compares
  initial begin
    forever begin
      @(negedge clock);
      if (mon_rd) begin
        mon_rd = 1'b0;
      end else if (auto_read && ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mon_data: got 0x%0h expected no byte", o_data);
        end else begin
          check("mon_data", int'(o_data), int'(exp_q.pop_front()));
        end
        mon_rd = 1'b1;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (5) @(negedge clock);
    check("rst_ready", int'(ready), 0);
    check("rst_data", int'(o_data), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_frame_err", int'(frame_err), 0);
    reset = 1'b0;
    repeat (5) @(negedge clock);

    // Single good frame, then empty FIFO keeps showing the last byte
    send_frame(8'h1C, 1'b0, 1'b0);
    repeat (4) @(negedge clock);
    pop_check("good1c");
    check("good1c_empty", int'(ready), 0);
    check("good1c_hold", int'(o_data), 8'h1C);
    check("good1c_noerr", err_seen, exp_err);

    // Parity error rejected, following frame accepted
    send_frame(8'h1C, 1'b1, 1'b0);
    repeat (4) @(negedge clock);
    check("badpar_err", err_seen, exp_err);
    check("badpar_ready", int'(ready), 0);
    send_frame(8'hF0, 1'b0, 1'b0);
    repeat (4) @(negedge clock);
    pop_check("f0");

    // Nine frames without reading: ninth dropped, overflow sticky until clr
    for (int i = 1; i <= 9; i++) begin
      if (i == 9) check("pre_overflow", int'(overflow), 0);
      send_frame(8'(i), 1'b0, 1'b0);
    end
    repeat (4) @(negedge clock);
    check("ovf_flag", int'(overflow), int'(exp_ovf));
    check("ovf_head", int'(o_data), 8'h01);
    for (int i = 0; i < 8; i++) pop_check("ovf_drain");
    check("ovf_empty", int'(ready), 0);
    check("ovf_still_set", int'(overflow), 1);
    clr = 1'b1;
    @(negedge clock);
    clr = 1'b0;
    exp_ovf = 1'b0;
    check("clr_overflow", int'(overflow), 0);

    // Full FIFO with a read in the push cycle: no byte lost
    for (int i = 1; i <= 8; i++) send_frame(8'(i), 1'b0, 1'b0);
    send_with_rd_at_push(8'h0A);
    repeat (4) @(negedge clock);
    check("simul_overflow", int'(overflow), 0);
    for (int i = 0; i < 8; i++) pop_check("simul_drain");
    check("simul_empty", int'(ready), 0);

    // Stalled frame abandoned after the timeout
    exp_err++;
    send_raw(8'h05, 1'b0, 1'b1, 4);
    repeat (2100) @(negedge clock);
    check("timeout_err", err_seen, exp_err);
    send_frame(8'h5A, 1'b0, 1'b0);
    repeat (4) @(negedge clock);
    pop_check("after_timeout");

    // Reset mid-frame discards it silently
    send_raw(8'hFF, 1'b0, 1'b1, 6);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    send_frame(8'h29, 1'b0, 1'b0);
    repeat (4) @(negedge clock);
    check("midrst_err", err_seen, exp_err);
    pop_check("midrst");
    check("midrst_count1", int'(ready), 0);

    // Random traffic drained by the monitor
    auto_read = 1'b1;
    for (int n = 0; n < 16; n++) begin
      int unsigned r;
      r = $urandom_range(0, 9);
      send_frame(8'($urandom), r == 0, r == 1);
      repeat ($urandom_range(0, 50)) @(negedge clock);
    end
    repeat (20) @(negedge clock);
    check("rand_drained", exp_q.size(), 0);
    check("rand_err", err_seen, exp_err);
    check("rand_overflow", int'(overflow), 0);
    check("rand_empty", int'(ready), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
